// File: rtl/atconv_pkg.sv
// Shared types and constants for the atconv memory responder: FSM states,
// memory geometry, data width and bank-select encodings.
package atconv_pkg;

  localparam int DW        = 13;
  localparam int IMG_DEPTH = 4096;
  localparam int L1_DEPTH  = 1024;

  localparam logic BANK_L0 = 1'b0;
  localparam logic BANK_L1 = 1'b1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/atconv_sram.sv
// Simple register-file memory: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module atconv_sram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 13,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/atconv_mem_resp.sv
// Memory responder for the atconv initiator: image load, handshake FSM and
// two layer banks. Optional access checking is enabled by ATCONV_RESP_CHK_EN.
module atconv_mem_resp #(
  parameter int IMG_DEPTH = atconv_pkg::IMG_DEPTH,
  parameter int L1_DEPTH  = atconv_pkg::L1_DEPTH,
  parameter int DW        = atconv_pkg::DW,
  localparam int AW       = $clog2(IMG_DEPTH),
  localparam int L1_AW    = $clog2(L1_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          csel,
  output logic          done,
  output logic          err
);
  import atconv_pkg::*;

  state_e        state_q;
  logic [AW-1:0] ld_cnt_q;
  logic          busy_q;
  logic          load_ready_q;
  logic          ready_q;
  logic          done_q;

  logic          run_s;
  logic          img_we_s;
  logic          l0_we_s;
  logic          l1_we_s;
  logic          l1_oob_s;
  logic [DW-1:0] l0_rd_s;
  logic [DW-1:0] l1_rd_s;

  assign run_s    = (state_q == ST_RUN);
  assign img_we_s = (state_q == ST_LOAD) && load_valid;
  assign l1_oob_s = (caddr_wr >= AW'(L1_DEPTH));
  assign l0_we_s  = cwr && run_s && (csel == BANK_L0);
  assign l1_we_s  = cwr && run_s && (csel == BANK_L1) && !l1_oob_s;

  // Load / arm / run / done sequencing with registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_LOAD;
      ld_cnt_q     <= '0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      busy_q <= busy;
      case (state_q)
        ST_LOAD: begin
          if (load_valid) begin
            ld_cnt_q <= ld_cnt_q + AW'(1);
            if (ld_cnt_q == AW'(IMG_DEPTH - 1)) begin
              state_q      <= ST_ARM;
              load_ready_q <= 1'b0;
              ready_q      <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (busy) begin
            state_q <= ST_RUN;
            ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (busy_q && !busy) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_LOAD;
          done_q       <= 1'b0;
          load_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_LOAD;
          ld_cnt_q     <= '0;
          load_ready_q <= 1'b1;
          ready_q      <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = load_ready_q;
  assign ready      = ready_q;
  assign done       = done_q;

  atconv_sram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_img (
    .clk   (clk),
    .we    (img_we_s),
    .waddr (ld_cnt_q),
    .wdata (load_data),
    .raddr (iaddr),
    .rdata (idata)
  );

  atconv_sram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_l0 (
    .clk   (clk),
    .we    (l0_we_s),
    .waddr (caddr_wr),
    .wdata (cdata_wr),
    .raddr (caddr_rd),
    .rdata (l0_rd_s)
  );

  // L1 is smaller; upper address bits are ignored on both ports
  atconv_sram #(.DEPTH(L1_DEPTH), .WIDTH(DW)) u_l1 (
    .clk   (clk),
    .we    (l1_we_s),
    .waddr (caddr_wr[L1_AW-1:0]),
    .wdata (cdata_wr),
    .raddr (caddr_rd[L1_AW-1:0]),
    .rdata (l1_rd_s)
  );

  assign cdata_rd = !crd ? '0 : ((csel == BANK_L1) ? l1_rd_s : l0_rd_s);

`ifdef ATCONV_RESP_CHK_EN
  logic [IMG_DEPTH-1:0] valid_q;
  logic                 err_q;
  logic                 viol_s;

  assign viol_s = (cwr && (csel == BANK_L1) && l1_oob_s)
               || (cwr && !run_s)
               || (crd && (csel == BANK_L0) && !valid_q[caddr_rd]);

  // Sticky error flag and per-word written tracking for L0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (l0_we_s) begin
        valid_q[caddr_wr] <= 1'b1;
      end
      if (viol_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_atconv_mem_resp.sv
// Self-checking bench for atconv_mem_resp: directed scenarios plus randomized
// RUN-phase traffic against array-based memory models.
module tb_atconv_mem_resp;

`ifdef ATCONV_RESP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_valid;
  logic [12:0] load_data;
  logic        load_ready;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [12:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [12:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [12:0] cdata_rd;
  logic        csel;
  logic        done;
  logic        err;

  logic [12:0] img_m [4096];
  logic [12:0] l0_m  [4096];
  logic [12:0] l1_m  [1024];
  int          l0_q[$];
  int          l1_q[$];
  bit          err_exp;
  int          total;
  int          bad;

  atconv_mem_resp dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total += 4;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready got=%b exp=1", load_ready); end
    if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 2000; i++) begin
      load_valid = 1'b1;
      load_data  = 13'($urandom);
      step();
    end
    load_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    total += 3;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL midrst_load_ready got=%b exp=1", load_ready); end
    if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    if (err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", err); end
    err_exp = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    for (int a = 0; a < 4096; a++) begin
      if ($urandom_range(0, 7) == 0) begin
        load_valid = 1'b0;
        step();
      end
      busy       = (a == 10);
      load_valid = 1'b1;
      load_data  = 13'(a);
      #1;
      total++;
      if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_word%0d got=%b exp=1", a, load_ready); end
      step();
      img_m[a] = 13'(a);
      busy     = 1'b0;
      if (a == 10) begin
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL busy_in_load_ready got=%b exp=0", ready); end
      end
    end
    load_valid = 1'b0;
    total += 2;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL load_done_load_ready got=%b exp=0", load_ready); end
    if (ready !== 1'b1) begin bad++; $display("FAIL load_done_ready got=%b exp=1", ready); end
    iaddr = 12'd100;
    #1;
    total++;
    if (idata !== 13'd100) begin bad++; $display("FAIL idata_100 got=%h exp=%h", idata, 13'd100); end
    for (int i = 0; i < 8; i++) begin
      iaddr = 12'($urandom);
      #1;
      total++;
      if (idata !== img_m[iaddr]) begin bad++; $display("FAIL idata_rand addr=%0d got=%h exp=%h", iaddr, idata, img_m[iaddr]); end
    end
  endtask

  task automatic test_ignore_in_arm();
    load_valid = 1'b1;
    load_data  = 13'h1abc;
    step();
    step();
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iaddr = 12'(i);
      #1;
      total++;
      if (idata !== img_m[i]) begin bad++; $display("FAIL arm_load_ignored addr=%0d got=%h exp=%h", i, idata, img_m[i]); end
    end
    total += 2;
    if (ready !== 1'b1) begin bad++; $display("FAIL arm_ready got=%b exp=1", ready); end
    if (load_ready !== 1'b0) begin bad++; $display("FAIL arm_load_ready got=%b exp=0", load_ready); end
  endtask

  task automatic test_arm_run();
    busy = 1'b1;
    step();
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL run_ready got=%b exp=0", ready); end
    cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd5; cdata_wr = 13'h0123;
    step();
    l0_m[5] = 13'h0123; l0_q.push_back(5);
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
    #1;
    total++;
    if (cdata_rd !== 13'h0123) begin bad++; $display("FAIL l0_rd5 got=%h exp=0123", cdata_rd); end
    cwr = 1'b1; cdata_wr = 13'h0456;
    #1;
    total++;
    if (cdata_rd !== 13'h0123) begin bad++; $display("FAIL same_cycle_old got=%h exp=0123", cdata_rd); end
    step();
    l0_m[5] = 13'h0456;
    cwr = 1'b0;
    #1;
    total++;
    if (cdata_rd !== 13'h0456) begin bad++; $display("FAIL same_cycle_new got=%h exp=0456", cdata_rd); end
    crd = 1'b0;
    #1;
    total++;
    if (cdata_rd !== 13'h0000) begin bad++; $display("FAIL crd0_zero got=%h exp=0000", cdata_rd); end
  endtask

  task automatic test_l1_bounds();
    cwr = 1'b1; csel = 1'b1; caddr_wr = 12'd1023; cdata_wr = 13'h0a5a;
    step();
    l1_m[1023] = 13'h0a5a; l1_q.push_back(1023);
    caddr_wr = 12'd4095; cdata_wr = 13'h15a5;
    step();
    if (CHK) err_exp = 1'b1;
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd1023;
    #1;
    total += 2;
    if (cdata_rd !== 13'h0a5a) begin bad++; $display("FAIL l1_oob_dropped got=%h exp=0a5a", cdata_rd); end
    if (err !== err_exp) begin bad++; $display("FAIL l1_oob_err got=%b exp=%b", err, err_exp); end
    caddr_rd = 12'd2047;
    #1;
    total++;
    if (cdata_rd !== 13'h0a5a) begin bad++; $display("FAIL l1_rd_upper_ignored got=%h exp=0a5a", cdata_rd); end
    crd = 1'b0;
  endtask

  task automatic test_random_run();
    logic        we;
    logic        sel;
    logic        rd;
    logic [11:0] wa;
    logic [11:0] ra;
    logic [12:0] wd;
    logic [12:0] exp_rd;
    for (int c = 0; c < 300; c++) begin
      we  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      wa  = 12'($urandom);
      if (sel && ($urandom_range(0, 3) != 0)) wa = {2'b00, wa[9:0]};
      wd  = 13'($urandom);
      rd  = 1'($urandom_range(0, 1));
      ra  = 12'd0;
      if (sel == 1'b0 && l0_q.size() == 0) rd = 1'b0;
      if (sel == 1'b1 && l1_q.size() == 0) rd = 1'b0;
      exp_rd = 13'h0000;
      if (rd) begin
        if (sel == 1'b0) begin
          ra     = 12'(l0_q[$urandom_range(0, l0_q.size() - 1)]);
          exp_rd = l0_m[ra];
        end else begin
          ra     = {2'($urandom), 10'(l1_q[$urandom_range(0, l1_q.size() - 1)])};
          exp_rd = l1_m[ra[9:0]];
        end
      end
      cwr = we; csel = sel; caddr_wr = wa; cdata_wr = wd; crd = rd; caddr_rd = ra;
      #1;
      total++;
      if (cdata_rd !== exp_rd) begin bad++; $display("FAIL rand_rd cyc=%0d sel=%b addr=%0d got=%h exp=%h", c, sel, ra, cdata_rd, exp_rd); end
      step();
      if (we) begin
        if (sel == 1'b0) begin
          l0_m[wa] = wd; l0_q.push_back(int'(wa));
        end else if (wa < 12'd1024) begin
          l1_m[wa] = wd; l1_q.push_back(int'(wa));
        end else if (CHK) begin
          err_exp = 1'b1;
        end
      end
    end
    cwr = 1'b0; crd = 1'b0;
    #1;
    total += 2;
    if (err !== err_exp) begin bad++; $display("FAIL rand_err got=%b exp=%b", err, err_exp); end
    if (done !== 1'b0) begin bad++; $display("FAIL run_done_low got=%b exp=0", done); end
  endtask

  task automatic test_done();
    busy = 1'b0;
    step();
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL done_pulse got=%b exp=1", done); end
    if (load_ready !== 1'b0) begin bad++; $display("FAIL done_load_ready got=%b exp=0", load_ready); end
    step();
    total += 3;
    if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    if (load_ready !== 1'b1) begin bad++; $display("FAIL after_done_load_ready got=%b exp=1", load_ready); end
    if (ready !== 1'b0) begin bad++; $display("FAIL after_done_ready got=%b exp=0", ready); end
  endtask

  task automatic test_write_outside_run();
    cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd5; cdata_wr = 13'h1fff;
    step();
    if (CHK) err_exp = 1'b1;
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
    #1;
    total += 2;
    if (cdata_rd !== l0_m[5]) begin bad++; $display("FAIL load_write_dropped got=%h exp=%h", cdata_rd, l0_m[5]); end
    if (err !== err_exp) begin bad++; $display("FAIL load_write_err got=%b exp=%b", err, err_exp); end
    crd = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; err_exp = 1'b0;
    reset_n = 1'b0; load_valid = 1'b0; load_data = 13'h0000; busy = 1'b0;
    iaddr = 12'd0; cwr = 1'b0; caddr_wr = 12'd0; cdata_wr = 13'h0000;
    crd = 1'b0; caddr_rd = 12'd0; csel = 1'b0;
    test_reset();
    test_reset_mid_load();
    test_load();
    test_ignore_in_arm();
    test_arm_run();
    test_l1_bounds();
    test_random_run();
    test_done();
    test_write_outside_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atconv_mem_resp.md
ATCONV_MEM_RESP -- requirements
Module: atconv_mem_resp

Interface
REQ-001 SHALL have parameters (name, default, meaning): IMG_DEPTH, 4096, image words; L1_DEPTH, 1024, layer-1 words; DW, 13, data width.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  image load word valid
- load_data  in  13  image load word, raster order
- load_ready  out  1  responder accepting image words
- ready  out  1  start request to the convolution initiator
- busy  in  1  initiator running
- iaddr  in  12  image read address
- idata  out  13  signed image data
- cwr  in  1  layer-memory write strobe
- caddr_wr  in  12  write address
- cdata_wr  in  13  write data
- crd  in  1  layer-memory read strobe
- caddr_rd  in  12  read address
- cdata_rd  out  13  read data
- csel  in  1  bank select: 0 = L0 (4096x13), 1 = L1 (1024x13)
- done  out  1  one-cycle completion pulse
- err  out  1  sticky access-error flag

Function
REQ-003 SHALL implement FSM LOAD -> ARM -> RUN -> DONE -> LOAD.
REQ-004 LOAD: load_ready=1; each cycle with load_valid=1 SHALL write load_data to img[ld_cnt] and increment 12-bit ld_cnt; the write of address 4095 SHALL move to ARM, wrapping ld_cnt to 0.
REQ-005 ARM: ready=1 until busy sampled 1; that edge SHALL enter RUN, and ready SHALL be 0 from the next cycle.
REQ-006 RUN: a busy falling edge (previous cycle 1, current cycle 0) SHALL enter DONE; DONE SHALL last exactly one cycle with done=1, then go to LOAD.
REQ-007 idata SHALL equal img[iaddr] combinationally (zero latency) in every state.
REQ-008 In RUN, when cwr=1 at a rising edge, the block SHALL write cdata_wr to L0[caddr_wr] (csel=0) or L1[caddr_wr[9:0]] (csel=1).
REQ-009 When csel=1 and caddr_wr>=1024, the block SHALL drop the L1 write.
REQ-010 Writes outside RUN SHALL be dropped.
REQ-011 cdata_rd SHALL equal bank[csel][caddr_rd] combinationally when crd=1, else 0.
REQ-012 For csel=1, reads SHALL use caddr_rd[9:0].
REQ-013 A read and a write to the same address in the same cycle SHALL return the old data; the new data SHALL be visible from the next cycle.
REQ-014 load_valid outside LOAD SHALL be ignored.
REQ-015 A busy rise in LOAD SHALL be ignored.
REQ-016 The block SHALL perform no arithmetic on data; it SHALL store and return all 13 bits unchanged.

Reset
REQ-017 reset_n=0 SHALL immediately force: state=LOAD, ld_cnt=0, load_ready=1, ready=0, done=0, err=0.
REQ-018 Memory arrays SHALL NOT be reset.
REQ-019 When reset_n=0 mid-RUN or mid-LOAD, the block SHALL abandon the operation; a new load SHALL restart from address 0.

Configuration
REQ-020 With ATCONV_RESP_CHK_EN defined, err SHALL set and stay set until reset on any of:
- L1 write with caddr_wr>=1024
- write outside RUN
- L0 read (crd=1, csel=0) of an address not written since reset, tracked by a 4096-bit valid vector cleared on reset
REQ-021 Without ATCONV_RESP_CHK_EN, err SHALL be tied 0 and the valid vector SHALL be absent.

Structure
REQ-022 A shared package atconv_pkg SHALL hold the FSM state enum, DW, IMG_DEPTH, L1_DEPTH, and the bank-select encodings.
REQ-023 One sub-module, atconv_sram (parameterised depth/width, one synchronous write port, one asynchronous read port), SHALL be instantiated three times (img, L0, L1).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load 4096 words img[a]=a: load_ready falls after word 4095, ready=1; set iaddr=100 -> idata=100.
- ARM, busy=1: ready=0 next cycle; cwr=1, csel=0, caddr_wr=5, cdata_wr=0x0123; next cycle crd=1, caddr_rd=5 -> cdata_rd=0x0123.
- Same-cycle write 0x0456 and read of L0[5]: cdata_rd=0x0123 that cycle, 0x0456 the next.
- csel=1, caddr_wr=4095 with CHK_EN: write dropped, err=1; without CHK_EN: err=0.
- busy falls in RUN: done=1 for exactly one cycle, then load_ready=1.
- reset_n=0 after 2000 loaded words: load_ready=1, ready=0; reload restarts at address 0.
